// File: rtl/load_store_unit.sv
// Load/store unit between a core request/response port and a 64-bit data memory.
// Handles byte/half/word/dword access with sign/zero extension and read-modify-write sub-dword stores.
`timescale 1ns/1ps
module load_store_unit #(
    parameter int DATA_WIDTH    = 64,
    parameter int ADDRESS_WIDTH = 6
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [1:0]               req_size,
    input  logic                     req_unsigned,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [DATA_WIDTH-1:0]    resp_rdata,
    output logic                     resp_misaligned,
    output logic [ADDRESS_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0]    mem_write_data,
    output logic                     mem_memorywrite,
    output logic                     mem_memoryread,
    input  logic [DATA_WIDTH-1:0]    mem_read_data
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t                   state_q, state_d;
    logic                     write_q, write_d;
    logic [1:0]               size_q, size_d;
    logic                     unsigned_q, unsigned_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]    line_q, line_d;
    logic                     misaligned_q, misaligned_d;

    logic                     reqMisaligned;
    logic [5:0]               shamt;
    logic [DATA_WIDTH-1:0]    shifted;
    logic [DATA_WIDTH-1:0]    loadData;
    logic [DATA_WIDTH-1:0]    sizeMask;
    logic [DATA_WIDTH-1:0]    mergedData;

    always_comb begin
        reqMisaligned = 1'b0;
        case (req_size)
            2'b01:   reqMisaligned = req_addr[0];
            2'b10:   reqMisaligned = |req_addr[1:0];
            2'b11:   reqMisaligned = |req_addr[2:0];
            default: reqMisaligned = 1'b0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        write_d      = write_q;
        size_d       = size_q;
        unsigned_d   = unsigned_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        line_d       = line_q;
        misaligned_d = misaligned_q;
        req_ready    = 1'b0;
        mem_memoryread = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    write_d      = req_write;
                    size_d       = req_size;
                    unsigned_d   = req_unsigned;
                    addr_d       = req_addr;
                    wdata_d      = req_wdata;
                    line_d       = '0;
                    misaligned_d = reqMisaligned;
                    // Full dword stores skip the read; partial stores need the old dword to merge into.
                    if (reqMisaligned)
                        state_d = RESP;
                    else if (req_write && req_size == 2'b11)
                        state_d = WRITE;
                    else
                        state_d = READ;
                end
            end
            READ: begin
                mem_memoryread = 1'b1;
                line_d         = mem_read_data;
                state_d        = write_q ? WRITE : RESP;
            end
            WRITE: state_d = RESP;
            RESP: begin
                if (resp_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            write_q      <= 1'b0;
            size_q       <= 2'b00;
            unsigned_q   <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            line_q       <= '0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            write_q      <= write_d;
            size_q       <= size_d;
            unsigned_q   <= unsigned_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            line_q       <= line_d;
            misaligned_q <= misaligned_d;
        end
    end

    always_comb begin
        shamt    = {addr_q[2:0], 3'b000};
        shifted  = line_q >> shamt;
        loadData = shifted;
        sizeMask = '1;
        case (size_q)
            2'b00: begin
                loadData = unsigned_q ? {56'b0, shifted[7:0]} : {{56{shifted[7]}}, shifted[7:0]};
                sizeMask = 64'h0000_0000_0000_00FF;
            end
            2'b01: begin
                loadData = unsigned_q ? {48'b0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
                sizeMask = 64'h0000_0000_0000_FFFF;
            end
            2'b10: begin
                loadData = unsigned_q ? {32'b0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
                sizeMask = 64'h0000_0000_FFFF_FFFF;
            end
            default: begin
                loadData = shifted;
                sizeMask = '1;
            end
        endcase
        // With a full mask the merge collapses to the store data, so one expression covers every size.
        mergedData = (line_q & ~(sizeMask << shamt)) | ((wdata_q & sizeMask) << shamt);
    end

    assign resp_valid      = (state_q == RESP);
    assign resp_misaligned = (state_q == RESP) && misaligned_q;
    assign resp_rdata      = ((state_q == RESP) && !write_q && !misaligned_q) ? loadData : '0;
    assign mem_address     = {addr_q[ADDRESS_WIDTH-1:3], 3'b000};
    assign mem_memorywrite = (state_q == WRITE) && rst_n;
    assign mem_write_data  = (state_q == WRITE) ? mergedData : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized scoreboard bench for load_store_unit against a byte-array memory model.
// A driver pushes expected responses; a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_write, req_unsigned;
    logic [1:0]  req_size;
    logic [5:0]  req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid, resp_ready, resp_misaligned;
    logic [63:0] resp_rdata;
    logic [5:0]  mem_address;
    logic [63:0] mem_write_data, mem_read_data;
    logic        mem_memorywrite, mem_memoryread;

    always #5 clk = ~clk;

    load_store_unit #(.DATA_WIDTH(64), .ADDRESS_WIDTH(6)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_misaligned(resp_misaligned),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_memorywrite(mem_memorywrite), .mem_memoryread(mem_memoryread),
        .mem_read_data(mem_read_data)
    );

    typedef struct {
        logic [63:0] rdata;
        logic        mis;
        int          due;
        int          reads;
        int          writes;
    } exp_t;

    exp_t        sbQ[$];
    logic [7:0]  mem[64];
    logic [7:0]  refMem[64];
    int          cycle = 0;
    int          checks = 0;
    int          failures = 0;
    int          readPulses = 0;
    int          writePulses = 0;
    int          doneCount = 0;
    int          holdLeft = 0;
    bit          directedReady = 1'b0;
    bit          inResp = 1'b0;
    bit          expectIdle = 1'b0;
    logic [63:0] heldData, lastRespData, lastWrData;
    logic        heldMis, lastRespMis;
    logic [5:0]  lastWrAddr;

    // Physical memory seen by the DUT: combinational little-endian read, write on rising edge.
    always_comb begin
        mem_read_data = '0;
        for (int i = 0; i < 8; i++)
            mem_read_data[8*i +: 8] = mem[mem_address + 6'(i)];
    end

    always @(posedge clk) begin
        cycle <= cycle + 1;
        if (mem_memorywrite) begin
            for (int i = 0; i < 8; i++)
                mem[mem_address + 6'(i)] = mem_write_data[8*i +: 8];
            lastWrAddr = mem_address;
            lastWrData = mem_write_data;
        end
    end

    always @(posedge clk) begin
        #2;
        if (holdLeft > 0 && resp_valid) begin
            resp_ready = 1'b0;
            holdLeft   = holdLeft - 1;
        end else if (directedReady) begin
            resp_ready = 1'b1;
        end else begin
            resp_ready = ($urandom_range(0, 2) != 0);
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: first response cycle pops the scoreboard, later cycles must hold steady.
    always @(negedge clk) begin
        if (!rst_n) begin
            readPulses  = 0;
            writePulses = 0;
            inResp      = 1'b0;
            expectIdle  = 1'b0;
        end else begin
            if (expectIdle) begin
                checkOutput("idleReady", 64'(req_ready), 64'd1);
                checkOutput("idleValid", 64'(resp_valid), 64'd0);
                expectIdle = 1'b0;
            end
            if (mem_memoryread)  readPulses++;
            if (mem_memorywrite) writePulses++;
            if (resp_valid) begin
                if (!inResp) begin
                    if (sbQ.size() == 0) begin
                        checks++;
                        failures++;
                        $display("[TB] FAIL unexpectedResp: got resp_valid=1 expected no response");
                    end else begin
                        exp_t e;
                        e = sbQ.pop_front();
                        checkOutput("latency", 64'(cycle), 64'(e.due));
                        checkOutput("rdata", resp_rdata, e.rdata);
                        checkOutput("misaligned", 64'(resp_misaligned), 64'(e.mis));
                        checkOutput("readPulses", 64'(readPulses), 64'(e.reads));
                        checkOutput("writePulses", 64'(writePulses), 64'(e.writes));
                    end
                    heldData     = resp_rdata;
                    heldMis      = resp_misaligned;
                    lastRespData = resp_rdata;
                    lastRespMis  = resp_misaligned;
                    inResp       = 1'b1;
                    readPulses   = 0;
                    writePulses  = 0;
                end else begin
                    checkOutput("holdData", resp_rdata, heldData);
                    checkOutput("holdMis", 64'(resp_misaligned), 64'(heldMis));
                end
                checkOutput("respReadyLow", 64'(req_ready), 64'd0);
                if (resp_ready) begin
                    inResp     = 1'b0;
                    expectIdle = 1'b1;
                    doneCount++;
                end
            end
        end
    end

    function automatic logic [63:0] modelLoad(input logic [5:0] a, input int n, input logic uns);
        logic [63:0] v;
        v = '0;
        for (int k = 0; k < n; k++)
            v = v + (64'(refMem[a + 6'(k)]) << (8 * k));
        if (!uns && n < 8 && v[8*n-1])
            v = v - (64'd1 << (8 * n));
        return v;
    endfunction

    task automatic setDword(input logic [5:0] a, input logic [63:0] v);
        for (int k = 0; k < 8; k++) begin
            mem[a + 6'(k)]    = v[8*k +: 8];
            refMem[a + 6'(k)] = v[8*k +: 8];
        end
    endtask

    task automatic applyStimulus(input logic w, input logic [1:0] sz, input logic uns,
                                 input logic [5:0] a, input logic [63:0] wd);
        int   n;
        int   waitCnt;
        int   startDone;
        exp_t e;
        waitCnt = 0;
        @(negedge clk);
        while (!req_ready && waitCnt < 50) begin
            @(negedge clk);
            waitCnt++;
        end
        if (!req_ready) begin
            checks++;
            failures++;
            $display("[TB] FAIL readyTimeout: got req_ready=0 expected 1 within 50 cycles");
            return;
        end
        n = 1 << sz;
        e.rdata = '0; e.mis = 1'b0; e.reads = 0; e.writes = 0;
        if ((int'(a) % n) != 0) begin
            e.mis = 1'b1;
            e.due = cycle + 1;
        end else if (!w) begin
            e.rdata = modelLoad(a, n, uns);
            e.reads = 1;
            e.due   = cycle + 2;
        end else begin
            for (int k = 0; k < n; k++)
                refMem[a + 6'(k)] = wd[8*k +: 8];
            e.writes = 1;
            e.reads  = (n == 8) ? 0 : 1;
            e.due    = cycle + ((n == 8) ? 2 : 3);
        end
        sbQ.push_back(e);
        startDone    = doneCount;
        req_write    = w;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = a;
        req_wdata    = wd;
        req_valid    = 1'b1;
        @(posedge clk);
        #1;
        req_valid    = 1'b0;
        req_write    = 1'($urandom);
        req_size     = 2'($urandom);
        req_unsigned = 1'($urandom);
        req_addr     = 6'($urandom);
        req_wdata    = {$urandom, $urandom};
        waitCnt = 0;
        while (doneCount == startDone && waitCnt < 60) begin
            @(negedge clk);
            waitCnt++;
        end
        if (doneCount == startDone) begin
            checks++;
            failures++;
            $display("[TB] FAIL respTimeout: got no response handshake expected one within 60 cycles");
        end
    endtask

    initial begin
        logic [1:0]  sz;
        logic [5:0]  a;
        logic [63:0] dw;
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
        for (int i = 0; i < 64; i++) begin
            mem[i]    = 8'($urandom);
            refMem[i] = mem[i];
        end
        repeat (3) @(negedge clk);
        checkOutput("rstRespValid", 64'(resp_valid), 64'd0);
        checkOutput("rstRdata", resp_rdata, 64'd0);
        checkOutput("rstStrobes", 64'({mem_memoryread, mem_memorywrite}), 64'd0);
        checkOutput("rstAddress", 64'(mem_address), 64'd0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checkOutput("postRstReady", 64'(req_ready), 64'd1);
        checkOutput("postRstMis", 64'(resp_misaligned), 64'd0);

        directedReady = 1'b1;
        setDword(6'd8, 64'h1122334455667788);
        applyStimulus(1'b0, 2'b11, 1'b0, 6'd8, '0);
        checkOutput("ldDword", lastRespData, 64'h1122334455667788);

        setDword(6'd8, 64'h00000000000080FF);
        applyStimulus(1'b0, 2'b00, 1'b0, 6'd9, '0);
        checkOutput("lbSigned", lastRespData, 64'hFFFFFFFFFFFFFF80);
        applyStimulus(1'b0, 2'b00, 1'b1, 6'd9, '0);
        checkOutput("lbUnsigned", lastRespData, 64'h0000000000000080);

        setDword(6'd16, 64'd0);
        applyStimulus(1'b1, 2'b01, 1'b0, 6'h12, 64'h000000000000BEEF);
        checkOutput("shWrAddr", 64'(lastWrAddr), 64'd16);
        checkOutput("shWrData", lastWrData, 64'h00000000BEEF0000);
        applyStimulus(1'b0, 2'b11, 1'b0, 6'd16, '0);
        checkOutput("shReadBack", lastRespData, 64'h00000000BEEF0000);

        applyStimulus(1'b0, 2'b10, 1'b0, 6'h06, '0);
        checkOutput("lwMisFlag", 64'(lastRespMis), 64'd1);

        holdLeft = 3;
        applyStimulus(1'b0, 2'b11, 1'b0, 6'd8, '0);
        holdLeft = 0;

        // Store interrupted by reset in its write cycle must leave memory untouched.
        dw = 64'h0123456789ABCDEF;
        setDword(6'd32, dw);
        @(negedge clk);
        req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 6'h21; req_wdata = 64'hAA; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("sbWriteCycle", 64'(mem_memorywrite), 64'd1);
        #1 rst_n = 1'b0;
        #1 checkOutput("sbWriteGated", 64'(mem_memorywrite), 64'd0);
        @(negedge clk);
        checkOutput("midRstValid", 64'(resp_valid), 64'd0);
        checkOutput("midRstAddress", 64'(mem_address), 64'd0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checkOutput("afterRstReady", 64'(req_ready), 64'd1);
        checkOutput("afterRstOutputs",
                    64'({resp_valid, resp_misaligned, mem_memoryread, mem_memorywrite}), 64'd0);
        checkOutput("afterRstRdata", resp_rdata, 64'd0);
        checkOutput("afterRstWdata", mem_write_data, 64'd0);
        checkOutput("afterRstAddress", 64'(mem_address), 64'd0);
        checkOutput("sbDroppedMem",
                    {mem[39], mem[38], mem[37], mem[36], mem[35], mem[34], mem[33], mem[32]}, dw);

        directedReady = 1'b0;
        for (int t = 0; t < 150; t++) begin
            sz = 2'($urandom);
            a  = 6'($urandom);
            if ($urandom_range(0, 3) != 0)
                a = a & ~6'((1 << sz) - 1);
            applyStimulus(1'($urandom), sz, 1'($urandom), a, {$urandom, $urandom});
        end

        repeat (3) @(negedge clk);
        for (int d = 0; d < 8; d++) begin
            logic [63:0] act, exp;
            for (int k = 0; k < 8; k++) begin
                act[8*k +: 8] = mem[6'(8 * d + k)];
                exp[8*k +: 8] = refMem[6'(8 * d + k)];
            end
            checkOutput("finalMem", act, exp);
        end
        checkOutput("sbEmpty", 64'(sbQ.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, 64, datapath width; only 64 is supported.
REQ-002 SHALL have parameter ADDRESS_WIDTH, 6, byte-address width of the data memory.
REQ-003 SHALL use one clock and a synchronous, active-low reset.
REQ-004 SHALL have port clk  in  1  clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  in  1  synchronous active-low reset.
REQ-006 SHALL have port req_valid  in  1  core request present.
REQ-007 SHALL have port req_ready  out  1  unit accepts request this cycle.
REQ-008 SHALL have port req_write  in  1  1 = store, 0 = load.
REQ-009 SHALL have port req_size  in  2  00 byte, 01 half, 10 word, 11 doubleword.
REQ-010 SHALL have port req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend.
REQ-011 SHALL have port req_addr  in  ADDRESS_WIDTH  byte address.
REQ-012 SHALL have port req_wdata  in  DATA_WIDTH  store data, right-aligned.
REQ-013 SHALL have port resp_valid  out  1  response present.
REQ-014 SHALL have port resp_ready  in  1  core consumes response.
REQ-015 SHALL have port resp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and errors.
REQ-016 SHALL have port resp_misaligned  out  1  request rejected as misaligned.
REQ-017 SHALL have ports mem_address out ADDRESS_WIDTH, mem_write_data out DATA_WIDTH, mem_memorywrite out 1, mem_memoryread out 1, mem_read_data in DATA_WIDTH: data-memory side (combinational read, 8 bytes little-endian from mem_address; write 8 bytes on rising edge when mem_memorywrite=1).

Function
REQ-018 SHALL implement FSM states IDLE, READ, WRITE, RESP; req_ready=1 only in IDLE.
REQ-019 SHALL register req_write, req_size, req_unsigned, req_addr, req_wdata on accept (req_valid && req_ready).
REQ-020 SHALL flag misaligned when addr is not a multiple of 2^req_size; IDLE -> RESP directly, resp_misaligned=1, no memory strobes.
REQ-021 SHALL drive mem_address = registered addr with bits [2:0] cleared (doubleword base); offset = addr[2:0].
REQ-022 Aligned load: IDLE -> READ -> RESP; mem_memoryread=1 only in READ; mem_read_data captured at end of READ; resp_valid first asserted 2 cycles after accept.
REQ-023 Load data SHALL be the size-selected bytes at offset, shifted to bit 0, sign- or zero-extended to 64 per req_unsigned; doubleword ignores req_unsigned.
REQ-024 Aligned doubleword store: IDLE -> WRITE -> RESP; mem_write_data = req_wdata; resp_valid 2 cycles after accept.
REQ-025 Aligned sub-doubleword store: IDLE -> READ -> WRITE -> RESP; merge low 8/16/32 bits of req_wdata into captured doubleword at offset, other bytes unchanged; resp_valid 3 cycles after accept.
REQ-026 mem_memorywrite SHALL be 1 for exactly one cycle per store (WRITE state) and SHALL be gated by rst_n.
REQ-027 RESP SHALL hold resp_valid, resp_rdata, resp_misaligned stable until resp_ready=1; then -> IDLE the next cycle.
REQ-028 mem_memoryread and mem_memorywrite SHALL be 0 in IDLE and RESP; mem_write_data 0 outside WRITE.
REQ-029 New request SHALL NOT be accepted in the cycle resp_ready handshake completes (one IDLE cycle minimum between operations).

Reset
REQ-030 rst_n low at a rising edge SHALL force IDLE and clear all registered fields; in-flight operation dropped, no response issued.
REQ-031 During and after reset: req_ready=1 (once rst_n high), resp_valid=0, resp_rdata=0, resp_misaligned=0, mem strobes 0, mem_address=0.
REQ-032 rst_n low while in WRITE SHALL suppress the memory write that cycle.

Verification
REQ-033 Dword@8=0x1122334455667788; LD addr 8 -> resp_valid at accept+2, rdata 0x1122334455667788, misaligned 0.
REQ-034 Dword@8=0x00000000000080FF; LB addr 9 -> rdata 0xFFFFFFFFFFFFFF80; LBU addr 9 -> 0x0000000000000080.
REQ-035 Dword@16=0; SH 0xBEEF addr 0x12 -> one-cycle write of 0x00000000BEEF0000 at mem_address 16, resp at accept+3; LD 16 returns same.
REQ-036 LW addr 0x06 -> resp at accept+1, resp_misaligned=1, rdata 0, no mem_memoryread/mem_memorywrite pulses.
REQ-037 LD with resp_ready held 0 for 3 cycles -> resp outputs stable, req_ready=0; resp_ready=1 -> IDLE next cycle.
REQ-038 SB 0xAA addr 0x21, rst_n low in WRITE cycle -> no write (dword@32 unchanged), IDLE and all outputs 0 next cycle.
